// File: rtl/mem_router_pkg.sv
// Shared types and helpers for the CPU memory request router.
package mem_router_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SRAM_ACC,
        SRAM_WAIT,
        EXT_CMD,
        EXT_RD,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        REG_SRAM,
        REG_EXT,
        REG_OOR
    } region_t;

    // Bits needed for a counter that must be able to hold max_count.
    function automatic int unsigned tmo_cnt_w(input int unsigned max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational region decode of a CPU word address plus the LPDDR2 word offset.
module mem_addr_decode
    import mem_router_pkg::*;
#(
    parameter int unsigned ADDR_W     = 30,
    parameter int unsigned SRAM_WORDS = 2048,
    parameter int unsigned EXT_AW     = 27
) (
    input  logic [ADDR_W-1:0] addr,
    output region_t           region_c,
    output logic [EXT_AW-1:0] ext_off_c
);

    // Two spare bits so the EXT upper bound never wraps.
    localparam int unsigned   CW       = ADDR_W + 2;
    localparam logic [CW-1:0] SRAM_LIM = CW'(SRAM_WORDS);
    localparam logic [CW-1:0] EXT_LIM  = SRAM_LIM + (CW'(1) << EXT_AW);

    logic [CW-1:0] addr_w;

    always_comb begin
        addr_w = CW'(addr);
        if (addr_w < SRAM_LIM) begin
            region_c = REG_SRAM;
        end else if (addr_w < EXT_LIM) begin
            region_c = REG_EXT;
        end else begin
            region_c = REG_OOR;
        end
        ext_off_c = EXT_AW'(addr - ADDR_W'(SRAM_WORDS));
    end

endmodule

// File: rtl/mem_router.sv
// Routes CPU ready/valid memory requests to on-chip SRAM or the LPDDR2 controller,
// with a bus timeout and out-of-range error responses.
module mem_router
    import mem_router_pkg::*;
#(
    parameter int unsigned ADDR_W     = 30,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SRAM_AW    = 12,
    parameter int unsigned SRAM_WORDS = 2048,
    parameter int unsigned SRAM_LAT   = 1,
    parameter int unsigned EXT_AW     = 27,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [EXT_AW-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_wdata,
    output logic              ext_read_req,
    output logic              ext_write_req,
    input  logic              ext_waitrequest,
    input  logic [DATA_W-1:0] ext_rdata,
    input  logic              ext_rdata_valid
);

    localparam int unsigned TW = tmo_cnt_w(TIMEOUT);

    if ((SRAM_WORDS > (1 << SRAM_AW)) || (SRAM_LAT < 1) || (SRAM_LAT > 3)) begin : g_cfg_check
        $error("mem_router: SRAM_WORDS must fit in SRAM_AW and SRAM_LAT must be 1..3");
    end

    state_t            state;
    logic              we_q;
    logic [TW-1:0]     tmo_cnt;
    region_t           dec_region;
    logic [EXT_AW-1:0] dec_ext_off;

    mem_addr_decode #(
        .ADDR_W    (ADDR_W),
        .SRAM_WORDS(SRAM_WORDS),
        .EXT_AW    (EXT_AW)
    ) u_decode (
        .addr     (req_addr),
        .region_c (dec_region),
        .ext_off_c(dec_ext_off)
    );

    // Single registered FSM; every output is set on the transition into the state that owns it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            tmo_cnt       <= '0;
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            busy          <= 1'b0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            sram_we       <= 1'b0;
            ext_addr      <= '0;
            ext_wdata     <= '0;
            ext_read_req  <= 1'b0;
            ext_write_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        we_q      <= req_we;
                        tmo_cnt   <= '0;
                        case (dec_region)
                            REG_SRAM: begin
                                state      <= SRAM_ACC;
                                sram_addr  <= SRAM_AW'(req_addr);
                                sram_wdata <= req_wdata;
                                sram_we    <= req_we;
                            end
                            REG_EXT: begin
                                state         <= EXT_CMD;
                                ext_addr      <= dec_ext_off;
                                ext_wdata     <= req_wdata;
                                ext_read_req  <= ~req_we;
                                ext_write_req <= req_we;
                            end
                            default: begin
                                state     <= RESP;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                                rsp_rdata <= '0;
                            end
                        endcase
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                SRAM_ACC: begin
                    sram_we <= 1'b0;
                    if (we_q || (SRAM_LAT <= 1)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= we_q ? '0 : sram_rdata;
                    end else begin
                        state <= SRAM_WAIT;
                    end
                end

                // Reuses the idle timeout counter to pace the extra SRAM latency.
                SRAM_WAIT: begin
                    if (tmo_cnt >= TW'(SRAM_LAT - 2)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= sram_rdata;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                EXT_CMD: begin
                    if (!ext_waitrequest) begin
                        ext_read_req  <= 1'b0;
                        ext_write_req <= 1'b0;
                        tmo_cnt       <= tmo_cnt + TW'(1);
                        if (we_q) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= '0;
                        end else begin
                            state <= EXT_RD;
                        end
                    end else if (tmo_cnt >= TW'(TIMEOUT - 1)) begin
                        ext_read_req  <= 1'b0;
                        ext_write_req <= 1'b0;
                        state         <= RESP;
                        rsp_valid     <= 1'b1;
                        rsp_err       <= 1'b1;
                        rsp_rdata     <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                // Read data arriving on the timeout cycle takes priority over the error.
                EXT_RD: begin
                    if (ext_rdata_valid) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= ext_rdata;
                    end else if (tmo_cnt >= TW'(TIMEOUT - 1)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                RESP: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_router.md
Name: mem_router

Overview:
- Single-clock, parametrised memory request router between the CPU data port, on-chip SRAM and the external LPDDR2 controller.
- Replaces the free-running enable-toggle scheme with a ready/valid request/response handshake and configurable region boundaries.
- Supports variable SRAM latency, LPDDR2 wait-request/read-valid flow control, a bus timeout, and out-of-range error reporting.

Parameters:
- ADDR_W, 30, CPU word-address width.
- DATA_W, 32, data width.
- SRAM_AW, 12, SRAM macro address width.
- SRAM_WORDS, 2048, words mapped to SRAM; CPU addresses 0..SRAM_WORDS-1.
- SRAM_LAT, 1, SRAM read latency in cycles (1..3).
- EXT_AW, 27, LPDDR2 word-address width; EXT region is SRAM_WORDS..SRAM_WORDS+2^EXT_AW-1.
- TIMEOUT, 255, max cycles spent in an EXT state before an error response.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset, asynchronous, active-high.
- req_valid, in, 1, CPU request present.
- req_we, in, 1, 1 = write, 0 = read.
- req_addr, in, ADDR_W, word address.
- req_wdata, in, DATA_W, write data.
- req_ready, out, 1, request accepted when req_valid & req_ready.
- rsp_valid, out, 1, one-cycle completion pulse (reads and writes).
- rsp_rdata, out, DATA_W, read data, valid with rsp_valid.
- rsp_err, out, 1, completion is an error (timeout or out-of-range).
- busy, out, 1, FSM not IDLE.
- sram_addr, out, SRAM_AW, SRAM address.
- sram_wdata, out, DATA_W, SRAM write data.
- sram_we, out, 1, SRAM write enable.
- sram_rdata, in, DATA_W, SRAM read data.
- ext_addr, out, EXT_AW, LPDDR2 word address.
- ext_wdata, out, DATA_W, LPDDR2 write data.
- ext_read_req, out, 1, LPDDR2 read request.
- ext_write_req, out, 1, LPDDR2 write request.
- ext_waitrequest, in, 1, controller not accepting the command.
- ext_rdata, in, DATA_W, LPDDR2 read data.
- ext_rdata_valid, in, 1, read data valid.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, timeout counter = 0. Reset mid-transaction drops ext_*_req immediately and discards the pending transaction. No response is ever issued for a transaction cut by reset.
- req_ready = 1 only in IDLE. On acceptance at cycle T, address, data and we are registered and region is decoded:
  - SRAM if addr < SRAM_WORDS.
  - EXT if SRAM_WORDS <= addr < SRAM_WORDS + 2^EXT_AW.
  - OOR otherwise.
- FSM states: IDLE, SRAM_ACC, SRAM_WAIT, EXT_CMD, EXT_RD, RESP.
- SRAM path:
  - SRAM_ACC (T+1): drive sram_addr = addr[SRAM_AW-1:0]; sram_we = req_we for exactly this cycle.
  - Write: go to RESP; rsp_valid at T+2.
  - Read: SRAM_WAIT counts SRAM_LAT-1 further cycles, then captures sram_rdata; rsp_valid at T+1+SRAM_LAT.
- EXT path:
  - EXT_CMD: ext_addr = (addr - SRAM_WORDS)[EXT_AW-1:0]; assert exactly one of ext_read_req / ext_write_req. Address, data and request are held stable until a cycle with ext_waitrequest = 0.
  - On acceptance: writes go to RESP; reads go to EXT_RD with the request deasserted.
  - EXT_RD: waits for ext_rdata_valid and captures ext_rdata, then goes to RESP.
  - ext_rdata_valid outside EXT_RD is ignored.
- Timeout:
  - Counter clears on entry to EXT_CMD and counts every cycle in EXT_CMD or EXT_RD.
  - When it reaches TIMEOUT: deassert requests, go to RESP with rsp_err = 1 and rsp_rdata = 0.
  - If ext_rdata_valid arrives in the same cycle the count reaches TIMEOUT, the data wins and no error is raised.
- OOR: no SRAM or EXT access; RESP at T+1 with rsp_err = 1 and rsp_rdata = 0.
- RESP: rsp_valid = 1 for one cycle, then IDLE. The next request can be accepted in the following cycle. rsp_rdata is held until the next response.
- Write responses carry rsp_rdata = 0.
- Address arithmetic is unsigned. SRAM_WORDS must be <= 2^SRAM_AW; this is checked by an elaboration-time assertion.

Decomposition:
- Package mem_router_pkg:
  - state enum (IDLE, SRAM_ACC, SRAM_WAIT, EXT_CMD, EXT_RD, RESP);
  - region enum (REG_SRAM, REG_EXT, REG_OOR);
  - timeout counter width helper function.
- Sub-module mem_addr_decode: combinational region decode plus EXT address offset. Parametrised by ADDR_W, SRAM_WORDS and EXT_AW.

Test Plan:
- SRAM write/read: write 0xDEADBEEF to addr 5, then read addr 5 (SRAM_LAT = 1) -> sram_we high one cycle at T+1; write rsp_valid at T+2; read returns 0xDEADBEEF at T+2, rsp_err = 0.
- Region boundary: read 2047 -> SRAM, sram_addr = 2047. Read 2048 -> EXT, ext_addr = 0, ext_read_req asserted.
- EXT write with ext_waitrequest high for 3 cycles -> ext_write_req and ext_addr held 4 cycles, then rsp_valid one cycle later, rsp_err = 0.
- EXT read timeout: ext_rdata_valid never asserted, TIMEOUT = 255 -> rsp_valid with rsp_err = 1 and rsp_rdata = 0. Next request accepted one cycle after RESP.
- OOR: addr = 2048 + 2^27 -> no sram_we, no ext_*_req; rsp_err = 1 at T+1.
- Reset mid-EXT read: assert rst while in EXT_RD -> ext_read_req and busy drop asynchronously. No rsp_valid after reset releases; req_ready = 1 in the next cycle.
